alu_mdu: RTL and testbench

Parametrised execute-stage arithmetic unit: a single-cycle combinational ALU with the team's 4-bit control encoding, plus a sequential iterative multiply/divide unit (MDU) with HI/LO result registers. Sits in EX alongside the existing `aluCtrl` decoder. The pipeline stalls on `md_busy`.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/mdu_iter.sv | 158 +++++++++++++++
 rtl/alu_mdu.sv | 69 ++++++
 tb/tb_alu_mdu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and the iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one result bit per cycle, sign fix-up, HI/LO registers
// and the mthi/mtlo write path.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [1:0]         op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dvz_q, dvz_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               sx, sy;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_top;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign sx = md_is_signed(md_op) & x[WIDTH-1];
  assign sy = md_is_signed(md_op) & y[WIDTH-1];

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_top >= {1'b0, opb_q});
    div_diff = div_top[WIDTH-1:0] - opb_q;
    div_next = {(div_ge ? div_diff : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    prod_fix = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    quo_fix  = mag(acc_q[WIDTH-1:0], neg_res_q);
    rem_fix  = mag(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dvz_d     = dvz_q;
    dvd_d     = dvd_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    unique case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (md_start) begin
          op_d      = md_op;
          neg_res_d = sx ^ sy;
          neg_rem_d = sx;
          dvz_d     = (y == '0);
          dvd_d     = x;
          opb_d     = mag(y, sy);
          acc_d     = {{WIDTH{1'b0}}, mag(x, sx)};
          cnt_d     = '0;
          state_d   = MD_CALC;
        end else begin
          if (hi_we) hi_d = x;
          if (lo_we) lo_d = x;
        end
      end
      MD_CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = MD_FIX;
      end
      MD_FIX: begin
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dvz_q) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
    busy_d = (state_d == MD_CALC) || (state_d == MD_FIX);
    done_d = (state_d == MD_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/working registers need no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    op_q      <= op_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    dvz_q     <= dvz_d;
    dvd_q     <= dvd_d;
    opb_q     <= opb_d;
    acc_q     <= acc_d;
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage arithmetic: combinational ALU alongside the iterative multiply/divide unit.
module alu_mdu
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic signed [WIDTH-1:0] x_s, y_s;
  logic [SHAMT_W-1:0]      shamt;
  logic [WIDTH-1:0]        alu_res;

  assign x_s   = x;
  assign y_s   = y;
  assign shamt = y[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    unique case (ctrl)
      ALU_AND:  alu_res = x & y;
      ALU_OR:   alu_res = x | y;
      ALU_ADD:  alu_res = x + y;
      ALU_XOR:  alu_res = x ^ y;
      ALU_NOR:  alu_res = ~(x | y);
      ALU_SLL:  alu_res = x << shamt;
      ALU_SUB:  alu_res = x - y;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (x_s < y_s)};
      ALU_SRA:  alu_res = x_s >>> shamt;
      ALU_SRL:  alu_res = x >> shamt;
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (x < y)};
      default:  alu_res = '0;
    endcase
  end

  assign out = alu_res;

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .md_start (md_start),
    .md_op    (md_op),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed plus randomized bench for alu_mdu at WIDTH=32 against an arithmetic reference model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ctrl;
  logic [31:0] x, y, out, hi, lo;
  logic        md_start, hi_we, lo_we, md_busy, md_done;
  logic [1:0]  md_op;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .x(x), .y(y), .out(out),
    .md_start(md_start), .md_op(md_op), .hi_we(hi_we), .lo_we(lo_we),
    .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    int unsigned sh;
    sa = a;
    sb = b;
    sh = b % 32;
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return ~(a | b);
      4'b0101: return a << sh;
      4'b0110: return a - b;
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: return 32'(sa >>> sh);
      4'b1001: return a >> sh;
      4'b1010: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint sp;
    longint unsigned up;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin sp = longint'(sa) * longint'(sb); rh = sp[63:32]; rl = sp[31:0]; end
      2'b01: begin up = longint'({32'h0, a}) * longint'({32'h0, b}); rh = up[63:32]; rl = up[31:0]; end
      2'b10: begin
        if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rh = 0; rl = 32'h8000_0000; end
        else begin rl = 32'(sa / sb); rh = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else begin rl = a / b; rh = a % b; end
      end
    endcase
  endtask

  // Starts an operation in the current cycle and follows it to md_done.
  task automatic run_md(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int glitch, input logic lo_with_start,
                        input logic hi_mid);
    logic [31:0] rh, rl;
    int cycles, busy_cnt;
    md_ref(op, a, b, rh, rl);
    md_op = op; x = a; y = b; md_start = 1'b1; lo_we = lo_with_start;
    @(posedge clk); #1;
    md_start = 1'b0; lo_we = 1'b0;
    cycles = 1; busy_cnt = 0;
    while (!md_done && cycles < 100) begin
      if (md_busy) busy_cnt++;
      if (cycles == glitch) begin
        md_start = 1'b1; md_op = 2'(($urandom) % 4); x = $urandom; y = $urandom;
      end
      if (hi_mid && cycles == 5) begin hi_we = 1'b1; x = 32'h1234; end
      @(posedge clk); #1;
      md_start = 1'b0; hi_we = 1'b0;
      cycles++;
    end
    exp_hi = rh;
    exp_lo = rl;
    chk({tag, "_done"}, 64'(md_done), 64'd1);
    chk({tag, "_latency"}, 64'(cycles), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_busy_at_done"}, 64'(md_busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int seen;
    logic [31:0] a, b;
    logic [1:0]  op;
    rst_n = 1'b0; ctrl = 4'h0; x = 0; y = 0;
    md_start = 0; md_op = 0; hi_we = 0; lo_we = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_done", 64'(md_done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    x = 32'hFFFF_FFFF; y = 32'd1;
    ctrl = 4'b0111; #1 chk("slt_neg1_1", 64'(out), 64'd1);
    ctrl = 4'b1010; #1 chk("sltu_ffff_1", 64'(out), 64'd0);
    x = 32'h8000_0000; y = 32'd4;
    ctrl = 4'b1000; #1 chk("sra_min_4", 64'(out), 64'hF800_0000);
    x = 32'd1; y = 32'd33;
    ctrl = 4'b0101; #1 chk("sll_1_33", 64'(out), 64'd2);
    ctrl = 4'b1011; #1 chk("undef_1011", 64'(out), 64'd0);
    for (int i = 0; i < 48; i++) begin
      ctrl = 4'(i % 16);
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      #1 chk($sformatf("alu_rand_c%0d", ctrl), 64'(out), 64'(alu_ref(ctrl, x, y)));
    end

    @(posedge clk); #1;
    run_md("mult_m3_7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 1'b0);
    run_md("divu_100_7", 2'b11, 32'd100, 32'd7, 0, 1'b0, 1'b0);
    run_md("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
    run_md("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    run_md("div_5_0", 2'b10, 32'd5, 32'd0, 0, 1'b0, 1'b0);
    run_md("divs_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 0, 1'b0, 1'b0);
    run_md("multu_glitch", 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 12, 1'b0, 1'b0);
    run_md("div_hiwe_busy", 2'b10, 32'd1000, 32'hFFFF_FFFD, 0, 1'b0, 1'b1);
    run_md("mult_lowe_start", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b1, 1'b0);

    @(posedge clk); #1;
    hi_we = 1'b1; x = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'h1234);
    chk("mthi_lo_kept", 64'(lo), 64'(exp_lo));
    hi_we = 1'b1; lo_we = 1'b1; x = 32'hCAFE_0001;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo_hi", 64'(hi), 64'hCAFE_0001);
    chk("mthilo_lo", 64'(lo), 64'hCAFE_0001);

    md_op = 2'b00; x = 32'hFFFF_FFFD; y = 32'd7; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", 64'(md_busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) seen++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 14; i++) begin
      op = 2'(($urandom) % 4);
      a = $urandom;
      b = $urandom;
      case ($urandom % 6)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_md($sformatf("rand%0d_op%0d", i, op), op, a, b, 0, 1'b0, 1'b0);
      if (i % 2 == 1) begin @(posedge clk); #1; end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
